// File: rtl/mem_engine_pkg.sv
// Shared types and widths for the data-memory access engine.
// AW and DW must match the single-port data memory the engine drives.
package mem_engine_pkg;

   localparam int AW = 8;
   localparam int DW = 8;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} eng_state_t;
   typedef enum logic {MODE_COPY, MODE_FILL} eng_mode_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Copy/fill engine that borrows the single-port data memory from the core.
// Copies move one byte per READ/WRITE pair in ascending order; fills write one byte per cycle.
module mem_copy_engine
   import mem_engine_pkg::*;
(
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Mode,
   input  logic [AW-1:0] SrcAddr,
   input  logic [AW-1:0] DstAddr,
   input  logic [AW-1:0] Length,
   input  logic [DW-1:0] FillValue,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   output logic          MemWE,
   input  logic [DW-1:0] MemRData,
   output logic          MemOwn,
   output logic          Busy,
   output logic          Done
);

   eng_state_t    state_q, state_d;
   eng_mode_t     mode_q, mode_d;
   logic [AW-1:0] srcPtr_q, srcPtr_d;
   logic [AW-1:0] dstPtr_q, dstPtr_d;
   logic [AW-1:0] remaining_q, remaining_d;
   logic [DW-1:0] hold_q, hold_d;
   logic [DW-1:0] fill_q, fill_d;

   // State and operand registers; reset abandons any operation in flight without a Done pulse.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         mode_q      <= MODE_COPY;
         srcPtr_q    <= '0;
         dstPtr_q    <= '0;
         remaining_q <= '0;
         hold_q      <= '0;
         fill_q      <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         srcPtr_q    <= srcPtr_d;
         dstPtr_q    <= dstPtr_d;
         remaining_q <= remaining_d;
         hold_q      <= hold_d;
         fill_q      <= fill_d;
      end
   end

   // Next-state logic and memory-port outputs, all decoded from the current registers.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      srcPtr_d    = srcPtr_q;
      dstPtr_d    = dstPtr_q;
      remaining_d = remaining_q;
      hold_d      = hold_q;
      fill_d      = fill_q;
      MemAddr     = '0;
      MemWData    = '0;
      MemWE       = 1'b0;
      MemOwn      = 1'b0;
      Busy        = 1'b0;
      Done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               mode_d      = eng_mode_t'(Mode);
               srcPtr_d    = SrcAddr;
               dstPtr_d    = DstAddr;
               remaining_d = Length;
               fill_d      = FillValue;
               if (Length == '0)
                  state_d = DONE;
               else if (Mode)
                  state_d = WRITE;
               else
                  state_d = READ;
            end
         end
         READ: begin
            MemOwn   = 1'b1;
            Busy     = 1'b1;
            MemAddr  = srcPtr_q;
            hold_d   = MemRData;
            srcPtr_d = srcPtr_q + 1'b1;
            state_d  = WRITE;
         end
         WRITE: begin
            MemOwn      = 1'b1;
            Busy        = 1'b1;
            MemAddr     = dstPtr_q;
            MemWData    = (mode_q == MODE_FILL) ? fill_q : hold_q;
            MemWE       = 1'b1;
            dstPtr_d    = dstPtr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            // Pointers wrap naturally at the top of memory; no range error is reported.
            if (remaining_q == AW'(1))
               state_d = DONE;
            else if (mode_q == MODE_FILL)
               state_d = WRITE;
            else
               state_d = READ;
         end
         DONE: begin
            MemOwn  = 1'b1;
            Done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a byte-level reference model predicts every write and Done,
// and a negedge monitor compares them plus Busy/MemOwn against the expected activity window.
module tb_mem_copy_engine;
   import mem_engine_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset, Start, Mode;
   logic [7:0] SrcAddr, DstAddr, Length, FillValue;
   logic [7:0] MemAddr, MemWData, MemRData;
   logic       MemWE, MemOwn, Busy, Done;

   mem_copy_engine dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
      .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
      .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRData(MemRData),
      .MemOwn(MemOwn), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   // Data memory the engine talks to, and the reference image the model maintains.
   logic [7:0] mem [256];
   logic [7:0] refMem [256];
   assign MemRData = mem[MemAddr];
   always @(posedge Clk) if (MemWE) mem[MemAddr] <= MemWData;

   int cycleCnt = 0;
   always @(posedge Clk) cycleCnt <= cycleCnt + 1;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   wr_t writeQ[$];
   int  doneQ[$];
   int  total = 0, bad = 0, writesSeen = 0;
   int  busyLo = 0, busyHi = 0, ownHi = 0;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Byte-level reference: bytes move in ascending order, each read before it is written.
   task automatic modelOp(input bit fill, input logic [7:0] src, input logic [7:0] dst,
                          input int len, input logic [7:0] fv, input int e, input int limit);
      logic [7:0] a, s, d;
      for (int i = 0; i < len && i < limit; i++) begin
         a = dst + 8'(i);
         s = src + 8'(i);
         d = fill ? fv : refMem[s];
         refMem[a] = d;
         writeQ.push_back('{addr: a, data: d, cyc: fill ? e + i : e + 2 * i + 1});
      end
      busyLo = e;
      busyHi = e + (fill ? len : 2 * len);
      ownHi  = busyHi + 1;
      if (limit >= len) doneQ.push_back(busyHi);
   endtask

   task automatic applyStimulus(input bit fill, input logic [7:0] src, input logic [7:0] dst,
                                input logic [7:0] len, input logic [7:0] fv, input int limit);
      int e;
      @(posedge Clk);
      #1;
      Start = 1'b1; Mode = fill; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fv;
      @(posedge Clk);
      #1;
      e = cycleCnt;
      Start = 1'b0;
      modelOp(fill, src, dst, int'(len), fv, e, limit);
   endtask

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while ((writeQ.size() != 0 || doneQ.size() != 0) && n < limit) begin
         @(negedge Clk);
         #1;
         n++;
      end
      if (writeQ.size() != 0 || doneQ.size() != 0) begin
         checkOutput("idleTimeout", 32'(writeQ.size() + doneQ.size()), 0);
         writeQ.delete();
         doneQ.delete();
      end
   endtask

   task automatic setMem(input logic [7:0] a, input logic [7:0] d);
      mem[a]    = d;
      refMem[a] = d;
   endtask

   // Monitor: compares every observed write and Done against the scoreboard queues.
   always @(negedge Clk) begin
      wr_t w;
      bit  expBusy, expOwn;
      expBusy = (cycleCnt >= busyLo) && (cycleCnt < busyHi);
      expOwn  = (cycleCnt >= busyLo) && (cycleCnt < ownHi);
      checkOutput("busy", 32'(Busy), 32'(expBusy));
      checkOutput("memOwn", 32'(MemOwn), 32'(expOwn));
      if (MemWE) begin
         writesSeen++;
         if (writeQ.size() == 0) begin
            checkOutput("unexpectedWrite", 32'(MemAddr), 32'hFFFF_FFFF);
         end else begin
            w = writeQ.pop_front();
            checkOutput("wrAddr", 32'(MemAddr), 32'(w.addr));
            checkOutput("wrData", 32'(MemWData), 32'(w.data));
            checkOutput("wrCycle", 32'(cycleCnt), 32'(w.cyc));
         end
      end
      if (doneQ.size() > 0 && doneQ[0] < cycleCnt) begin
         checkOutput("doneMissed", 32'(cycleCnt), 32'(doneQ[0]));
         void'(doneQ.pop_front());
      end
      if (Done) begin
         if (doneQ.size() == 0)
            checkOutput("unexpectedDone", 32'(cycleCnt), 32'hFFFF_FFFF);
         else
            checkOutput("doneCycle", 32'(cycleCnt), 32'(doneQ.pop_front()));
      end
   end

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "MemWE"}, 32'(MemWE), 0);
      checkOutput({tag, "MemOwn"}, 32'(MemOwn), 0);
      checkOutput({tag, "Busy"}, 32'(Busy), 0);
      checkOutput({tag, "Done"}, 32'(Done), 0);
   endtask

   initial begin
      int n, target;
      Reset = 1'b1; Start = 1'b0; Mode = 1'b0;
      SrcAddr = '0; DstAddr = '0; Length = '0; FillValue = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 8'($urandom);
         refMem[i] = mem[i];
      end
      repeat (2) @(posedge Clk);
      #1;
      checkQuiet("reset");
      checkOutput("resetMemAddr", 32'(MemAddr), 0);
      Reset = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
      checkQuiet("idle");

      $display("[TB] directed copy with Start held during the operation");
      setMem(8'd16, 8'hA1); setMem(8'd17, 8'hB2); setMem(8'd18, 8'hC3);
      applyStimulus(1'b0, 8'd16, 8'd100, 8'd3, 8'h00, 999);
      Start = 1'b1; Mode = 1'b1; DstAddr = 8'd0; Length = 8'd5;
      repeat (4) @(posedge Clk);
      #1;
      Start = 1'b0;
      waitIdle(50);

      $display("[TB] fill wrapping past address 255");
      applyStimulus(1'b1, 8'd0, 8'd254, 8'd4, 8'h5A, 999);
      waitIdle(50);

      $display("[TB] zero-length copy with Start high on the DONE cycle");
      applyStimulus(1'b0, 8'd20, 8'd30, 8'd0, 8'h00, 999);
      Start = 1'b1; Mode = 1'b1; DstAddr = 8'd200; Length = 8'd2; FillValue = 8'hEE;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      waitIdle(10);
      repeat (4) @(posedge Clk);

      $display("[TB] forward-overlapping copy");
      setMem(8'd10, 8'd1); setMem(8'd11, 8'd2); setMem(8'd12, 8'd3); setMem(8'd13, 8'd4);
      applyStimulus(1'b0, 8'd10, 8'd11, 8'd3, 8'h00, 999);
      waitIdle(50);

      $display("[TB] reset in the middle of a copy");
      applyStimulus(1'b0, 8'd0, 8'd50, 8'd8, 8'h00, 3);
      target = writesSeen + 3;
      n = 0;
      while (writesSeen < target && n < 40) begin
         @(negedge Clk);
         #1;
         n++;
      end
      checkOutput("writesBeforeReset", 32'(writesSeen), 32'(target));
      @(posedge Clk);
      #1;
      Reset  = 1'b1;
      busyHi = cycleCnt + 1;
      ownHi  = busyHi;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      checkQuiet("afterReset");
      applyStimulus(1'b1, 8'd0, 8'd60, 8'd2, 8'h33, 999);
      waitIdle(50);

      $display("[TB] randomized operations");
      for (int k = 0; k < 25; k++) begin
         applyStimulus(1'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom_range(0, 30)), 8'($urandom), 999);
         waitIdle(100);
      end
      repeat (3) @(posedge Clk);
      #1;

      for (int i = 0; i < 256; i++)
         checkOutput($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(refMem[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
